// File: rtl/seg7_scan_pkg.sv
// seg7_scan_pkg: shared constants for the six-digit multiplexed seven-segment scanner
package seg7_scan_pkg;
  localparam int NUM_DIGITS = 6;
  localparam int COLON_A = 1;
  localparam int COLON_B = 3;
  // Active-low {g,f,e,d,c,b,a}; element 9 is listed first.
  localparam logic [9:0][6:0] SEG_DIGITS = {7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
                                            7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD nibble to active-low segment pattern, non-decimal codes render a dash
module seg7_decode
  import seg7_scan_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  always_comb seg = nib < 4'd10 ? SEG_DIGITS[nib] : SEG_DASH;
endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: six-digit HH:MM:SS multiplexed display scanner with guard band and colon.
// Define SEG7_SCAN_BLINK_EN to enable per-digit blinking via blink_mask.
module seg7_scan
  import seg7_scan_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int GUARD_CYC = 4,
  parameter int BLINK_DIV = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [23:0] bcd_in,
  input  logic [5:0]  blink_mask,
  output logic [5:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);
  localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  logic [PW-1:0] pre;
  logic [2:0]    idx;
  logic [23:0]   shadow;
  logic [3:0]    nib;
  logic [6:0]    seg_d;
  logic          term, lit, colon, frame_end, blank;
  always_comb begin
    term      = pre == PW'(SCAN_DIV - 1);
    lit       = pre >= PW'(GUARD_CYC);
    colon     = idx == 3'(COLON_A) || idx == 3'(COLON_B);
    frame_end = term && idx == 3'(NUM_DIGITS - 1);
    nib       = shadow[23 - 4*idx -: 4];
  end
  seg7_decode u_dec (.nib(nib), .seg(seg_d));
`ifdef SEG7_SCAN_BLINK_EN
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0] bcnt;
  logic          hidden;
  logic          bwrap;
  assign bwrap = bcnt == BW'(BLINK_DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bcnt   <= '0;
      hidden <= 1'b0;
    end else if (!en) begin
      bcnt   <= '0;
      hidden <= 1'b0;
    end else if (frame_end) begin
      bcnt   <= bwrap ? '0 : bcnt + 1'b1;
      hidden <= bwrap ? !hidden : hidden;
    end
  assign blank = hidden & blink_mask[idx];
`else
  logic unused_mask;
  assign unused_mask = ^{blink_mask, frame_end};
  assign blank = 1'b0;
`endif
  // Outputs are registered from the same pre/idx so an, seg and dp never skew.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      shadow <= '0;
      pre    <= '0;
      idx    <= '0;
      an     <= '1;
      seg    <= '1;
      dp     <= 1'b1;
    end else begin
      if (load) shadow <= bcd_in;
      if (!en) begin
        pre <= '0;
        idx <= '0;
        an  <= '1;
        seg <= '1;
        dp  <= 1'b1;
      end else begin
        pre <= term ? '0 : pre + 1'b1;
        if (term) idx <= idx == 3'(NUM_DIGITS - 1) ? 3'd0 : idx + 3'd1;
        an  <= lit ? ~(6'b1 << idx) : '1;
        seg <= (!lit || blank) ? SEG_BLANK : seg_d;
        dp  <= !(lit && colon && !blank);
      end
    end
endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: randomized bench for seg7_scan against a slot-arithmetic reference model
module tb_seg7_scan;
  localparam int SCAN_DIV = 8;
  localparam int GUARD_CYC = 2;
  localparam int BLINK_DIV = 2;
  logic clk = 1'b0;
  logic rst_n, en, load;
  logic [23:0] bcd_in;
  logic [5:0]  blink_mask;
  logic [5:0]  an;
  logic [6:0]  seg;
  logic        dp;
  int checks = 0;
  int errors = 0;
  int m_t;
  logic [23:0] m_sh;
  logic [13:0] m_exp;
  logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  seg7_scan #(.SCAN_DIV(SCAN_DIV), .GUARD_CYC(GUARD_CYC), .BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .bcd_in(bcd_in),
    .blink_mask(blink_mask), .an(an), .seg(seg), .dp(dp)
  );
  always #5 clk = ~clk;
  // t counts enabled cycles since the last clear; slot, digit and frame follow by division.
  function automatic logic [13:0] model_out(int t, logic [23:0] sh, logic [5:0] mask);
    int pre, idx, frame;
    logic [3:0] nib;
    logic [6:0] s;
    logic blank;
    pre = t % SCAN_DIV;
    idx = (t / SCAN_DIV) % 6;
    frame = t / (SCAN_DIV * 6);
    if (pre < GUARD_CYC) return '1;
    nib = 4'((sh >> (20 - 4 * idx)) & 24'hf);
    s = nib < 10 ? pat[nib] : 7'b0111111;
`ifdef SEG7_SCAN_BLINK_EN
    blank = ((frame / BLINK_DIV) % 2 == 1) && mask[idx];
`else
    blank = 1'b0;
`endif
    return {~(6'b1 << idx), blank ? 7'b1111111 : s, !((idx == 1 || idx == 3) && !blank)};
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_t   <= 0;
      m_sh  <= '0;
      m_exp <= '1;
    end else begin
      m_exp <= en ? model_out(m_t, m_sh, blink_mask) : '1;
      m_t   <= en ? m_t + 1 : 0;
      if (load) m_sh <= bcd_in;
    end
  task automatic lit_chk(input string name, input logic [13:0] got, input logic [13:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      checks++;
      if ({an, seg, dp} !== m_exp) begin
        errors++;
        $display("FAIL model t=%0d got an=%b seg=%b dp=%b want %b", m_t, an, seg, dp, m_exp);
      end
    end
  endtask
  task automatic wait_slot(input string name, input int d, input int p);
    int n = 0;
    while (!(((m_t / SCAN_DIV) % 6) == d && (m_t % SCAN_DIV) == p) && n < 1000) begin
      cyc(1);
      n++;
    end
    if (n >= 1000) lit_chk({name, "_timeout"}, 14'd0, 14'd1);
  endtask
  initial begin
    rst_n = 1'b0; en = 1'b0; load = 1'b0; bcd_in = '0; blink_mask = '0;
    cyc(2);
    lit_chk("reset", {an, seg, dp}, 14'h3fff);
    rst_n = 1'b1; en = 1'b1; load = 1'b1; bcd_in = 24'h123456;
    cyc(1);
    load = 1'b0;
    lit_chk("guard0", {an, seg, dp}, 14'h3fff);
    cyc(2);
    lit_chk("digit0", {an, seg, dp}, {6'b111110, 7'b1111001, 1'b1});
    cyc(8);
    lit_chk("digit1_colon", {an, seg, dp}, {6'b111101, 7'b0100100, 1'b0});
    load = 1'b1; bcd_in = 24'h0A0000;
    cyc(1);
    load = 1'b0;
    cyc(1);
    lit_chk("dash_colon", {an, seg, dp}, {6'b111101, 7'b0111111, 1'b0});
    load = 1'b1; bcd_in = 24'h999999;
    cyc(1);
    load = 1'b0;
    wait_slot("slot2_term", 2, SCAN_DIV - 1);
    load = 1'b1; bcd_in = 24'h000000;
    cyc(1);
    load = 1'b0;
    cyc(2);
    lit_chk("slot3_guard", {an, seg, dp}, 14'h3fff);
    cyc(1);
    lit_chk("slot3_new", {an, seg, dp}, {6'b110111, 7'b1000000, 1'b0});
    wait_slot("slot4_mid", 4, 4);
    #2 rst_n = 1'b0;
    #1 lit_chk("async_reset", {an, seg, dp}, 14'h3fff);
    cyc(1);
    rst_n = 1'b1;
    cyc(3);
    lit_chk("after_reset_idx0", {an, seg, dp}, {6'b111110, 7'b1000000, 1'b1});
    load = 1'b1; bcd_in = 24'h123456;
    cyc(3);
    load = 1'b0;
    en = 1'b0;
    cyc(1);
    lit_chk("en_off", {an, seg, dp}, 14'h3fff);
    cyc(2);
    en = 1'b1;
    cyc(2);
    lit_chk("en_guard", {an, seg, dp}, 14'h3fff);
    cyc(1);
    lit_chk("en_restart", {an, seg, dp}, {6'b111110, 7'b1111001, 1'b1});
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1; load = 1'b1; bcd_in = 24'h123456; blink_mask = 6'b000001;
    cyc(1);
    load = 1'b0;
    cyc(98);
`ifdef SEG7_SCAN_BLINK_EN
    lit_chk("blink_frame2", {an, seg, dp}, {6'b111110, 7'b1111111, 1'b1});
`else
    lit_chk("blink_frame2", {an, seg, dp}, {6'b111110, 7'b1111001, 1'b1});
`endif
    cyc(96);
    lit_chk("blink_frame4", {an, seg, dp}, {6'b111110, 7'b1111001, 1'b1});
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom % 200) != 0;
      load = ($urandom % 16) == 0;
      bcd_in = 24'($urandom);
      if ($urandom % 100 == 0) blink_mask = 6'($urandom);
      cyc(1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 SHALL provide parameter SCAN_DIV, default 50000: clock cycles per digit slot, minimum GUARD_CYC+2.
REQ-002 SHALL provide parameter GUARD_CYC, default 4: cycles at slot start with all anodes off (anti-ghosting).
REQ-003 SHALL provide parameter BLINK_DIV, default 32: full 6-digit frames per blink half-period.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port en, input, 1 bit: scan enable.
REQ-007 SHALL have port load, input, 1 bit: one-cycle strobe that captures bcd_in.
REQ-008 SHALL have port bcd_in, input, 24 bits: six BCD digits HH:MM:SS, [23:20] leftmost.
REQ-009 SHALL have port blink_mask, input, 6 bits: bit k=1 blinks digit k, bit 0 leftmost.
REQ-010 SHALL have port an, output, 6 bits: active-low digit enables, an[k] drives digit k.
REQ-011 SHALL have port seg, output, 7 bits: active-low segments {g,f,e,d,c,b,a}.
REQ-012 SHALL have port dp, output, 1 bit: active-low decimal point, used as colon.

Function
REQ-013 SHALL hold a 24-bit shadow register written with bcd_in on every clock with load=1; the display reads only the shadow, so no digit tears mid-slot.
REQ-014 SHALL run prescaler 0..SCAN_DIV-1; at terminal count the digit index SHALL advance 0->1->...->5->0.
REQ-015 SHALL drive an all-ones while prescaler < GUARD_CYC; otherwise an SHALL be all ones except bit idx=0.
REQ-016 SHALL drive seg from the shadow nibble of digit idx: 0-9 standard patterns (0=1000000, 1=1111001, 8=0000000); 10-15 render dash 0111111.
REQ-017 SHALL register seg, an and dp together, so all three reflect the same idx and prescaler with exactly one cycle latency.
REQ-018 SHALL drive dp=0 on idx 1 and 3 when that digit is not blanked, else 1.
REQ-019 When en=0, SHALL force an=111111, seg=1111111, dp=1 and synchronously clear prescaler, idx and blink counter; the shadow SHALL still accept load.
REQ-020 When load coincides with the prescaler terminal count, the new shadow value SHALL be displayed from the first lit cycle of the next slot.
REQ-021 A blanked digit SHALL drive seg=1111111 and dp=1, with an timing unchanged.

Reset
REQ-022 While rst_n=0 SHALL drive an=111111, seg=1111111, dp=1, with shadow=0, idx=0, prescaler=0, blink counter=0 and blink phase=visible.
REQ-023 Reset asserted mid-slot SHALL take effect immediately, independent of clk; after release, scanning SHALL restart at idx 0.

Configuration
REQ-024 With macro SEG7_SCAN_BLINK_EN defined, a frame counter SHALL toggle blink phase every BLINK_DIV frames, and during the hidden phase digits with blink_mask=1 SHALL be blanked.
REQ-025 Without SEG7_SCAN_BLINK_EN, SHALL omit the blink counter, ignore blink_mask and never blank a digit.

Structure
REQ-026 A shared package SHALL hold segment pattern constants (digits 0-9, dash, blank), NUM_DIGITS=6 and the colon digit indices.
REQ-027 Nibble-to-segment decode SHALL be a combinational sub-module seg7_decode instantiated once.

Verification (SCAN_DIV=8, GUARD_CYC=2, BLINK_DIV=2)
REQ-028 Reset, en=1, load bcd_in=0x123456 -> per slot: 2 cycles an=111111, then 6 cycles lit; digit 0 seg=1111001; digits cycle 0..5 and wrap.
REQ-029 Load 0x0A0000 -> digit 1 seg=0111111 (dash) and dp=0 on digit 1.
REQ-030 Load 0x999999 held, then load 0x000000 on the terminal cycle of slot 2 -> slot 3 first lit cycle seg=1000000.
REQ-031 With SEG7_SCAN_BLINK_EN, blink_mask=000001 -> digit 0 blank for frames 2-3, lit for frames 0-1 and 4-5; without the macro it is always lit.
REQ-032 rst_n low mid-slot 4 -> outputs all ones with no clock edge; after release the first lit slot is idx 0.
REQ-033 en low for 3 cycles mid-slot -> outputs all ones; on re-enable the prescaler restarts at 0 and idx restarts at 0.
